// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM, ALU/immediate decode, and conditional
// execution with the NZCV flag register. Define MC_CTRL_CMP_EN to decode CMP.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       rd_is_pc;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign cmd       = funct[4:1];
  assign rd        = Instr[3:0];
  assign rd_is_pc  = (rd == 4'd15);
  assign unused_rn = ^Instr[7:4];

  // Condition evaluation always uses the stored flags, never the live ALU flags.
  logic cond_met;
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    case (cond)
      4'b0000: cond_met = z;
      4'b0001: cond_met = !z;
      4'b0010: cond_met = c;
      4'b0011: cond_met = !c;
      4'b0100: cond_met = n;
      4'b0101: cond_met = !n;
      4'b0110: cond_met = v;
      4'b0111: cond_met = !v;
      4'b1000: cond_met = c && !z;
      4'b1001: cond_met = !c || z;
      4'b1010: cond_met = (n == v);
      4'b1011: cond_met = (n != v);
      4'b1100: cond_met = !z && (n == v);
      4'b1101: cond_met = z || (n != v);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  logic [1:0] dp_alu;
  logic       dp_wr;
  logic       dp_nz_only;
  logic       dp_cmp;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    dp_alu     = 2'b00;
    dp_wr      = 1'b0;
    dp_nz_only = 1'b0;
    dp_cmp     = 1'b0;
    case (cmd)
      4'b0100: dp_wr = 1'b1;
      4'b0010: begin dp_alu = 2'b01; dp_wr = 1'b1; end
      4'b0000: begin dp_alu = 2'b10; dp_wr = 1'b1; dp_nz_only = 1'b1; end
      4'b1100: begin dp_alu = 2'b11; dp_wr = 1'b1; dp_nz_only = 1'b1; end
`ifdef MC_CTRL_CMP_EN
      4'b1010: if (funct[0]) begin dp_alu = 2'b01; dp_cmp = 1'b1; end
`endif
      default: ;
    endcase
  end

  logic pc_w, mem_w, reg_w, ir_w;

  always_comb begin
    state_d    = state_q;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = Instr[11] ? 2'b00 : 2'b01;
        state_d    = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = condex_q;
        pc_w      = condex_q && rd_is_pc;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        mem_w   = condex_q;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = dp_alu;
        state_d    = dp_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = condex_q && dp_wr;
        pc_w    = condex_q && dp_wr && rd_is_pc;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
        pc_w    = condex_q;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    flags_d  = flags_q;
    condex_d = (state_q == S_DECODE) ? cond_met : condex_q;
    if ((state_q == S_EXECR || state_q == S_EXECI) && funct[0] && condex_q &&
        (dp_wr || dp_cmp)) begin
      if (dp_nz_only) flags_d[3:2] = ALUFlags[3:2];
      else            flags_d      = ALUFlags;
    end
  end

  assign RegSrc   = {(op == 2'b01) && !funct[0], (op == 2'b10)};
  assign ImmSrc   = (op == 2'b11) ? 2'b00 : op;
  // Write strobes are suppressed for the whole reset cycle, whatever the state.
  assign PCWrite  = pc_w  && !reset;
  assign MemWrite = mem_w && !reset;
  assign RegWrite = reg_w && !reset;
  assign IRWrite  = ir_w  && !reset;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

endmodule
